// File: rtl/handle_move_multi.sv
// Multi-card move handler: the active player picks a horizontal run of 1..MAX_SEL
// cards, confirms with a right click, then drops the run on a target cell.
`ifndef P1
`define P1 0
`endif
`ifndef P2
`define P2 1
`endif
`ifndef GAME_P1_WAIT_IN
`define GAME_P1_WAIT_IN 4'd2
`endif
`ifndef GAME_P2_WAIT_IN
`define GAME_P2_WAIT_IN 4'd6
`endif
`ifndef TABLE_TAKE
`define TABLE_TAKE 4'd1
`endif
`ifndef HAND_TAKE
`define HAND_TAKE 4'd2
`endif
`ifndef TABLE_DOWN
`define TABLE_DOWN 4'd3
`endif
`ifndef HAND_DOWN
`define HAND_DOWN 4'd4
`endif

module handle_move_multi #(
  parameter int PLAYER     = `P1,
  parameter int COLS       = 18,
  parameter int ROWS       = 8,
  parameter int TABLE_ROWS = 6,
  parameter int CARD_W     = 6,
  parameter int MAX_SEL    = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          interboard_rst,
  input  logic [3:0]                    cur_game_state,
  input  logic                          inter_ready,
  input  logic                          valid_card_take,
  input  logic                          valid_card_down,
  input  logic [COLS*ROWS*CARD_W-1:0]   map,
  input  logic                          l_click,
  input  logic                          r_click,
  input  logic [4:0]                    mouse_block_x,
  input  logic [2:0]                    mouse_block_y,
  output logic                          move_done,
  output logic [COLS*ROWS-1:0]          move_sel_card,
  output logic                          move_ctrl_en,
  output logic                          move_ctrl_move_dir,
  output logic [4:0]                    move_ctrl_block_x,
  output logic [2:0]                    move_ctrl_block_y,
  output logic [3:0]                    move_ctrl_msg_type,
  output logic [CARD_W-1:0]             move_ctrl_card,
  output logic [2:0]                    move_ctrl_sel_len,
  output logic [2:0]                    dbg_state
);

  localparam int NCELL = COLS * ROWS;
  localparam int IDX_W = $clog2(NCELL + 32);
  localparam logic [NCELL-1:0] ONE_CELL = NCELL'(1);
  localparam logic [2:0] MAX_LEN = 3'(MAX_SEL);
  localparam logic [6:0] COLS_7  = 7'(COLS);
  localparam logic [3:0] TROWS_4 = 4'(TABLE_ROWS);

  localparam logic [2:0] S_IDLE           = 3'd0;
  localparam logic [2:0] S_SELECT         = 3'd1;
  localparam logic [2:0] S_WAIT_SEND_TAKE = 3'd2;
  localparam logic [2:0] S_WAIT_DOWN      = 3'd3;
  localparam logic [2:0] S_WAIT_SEND_DOWN = 3'd4;
  localparam logic [2:0] S_FIN            = 3'd5;

  logic [2:0]        r_state;
  logic [4:0]        r_anchor_x, r_end_x, r_bx;
  logic [2:0]        r_anchor_y, r_by, r_len, r_sel_len;
  logic [CARD_W-1:0] r_first_card, r_card;
  logic [NCELL-1:0]  r_sel;
  logic [3:0]        r_msg;
  logic              r_en, r_done;

  logic              w_active, w_extend, w_on_anchor, w_fits;
  logic [IDX_W-1:0]  w_idx;
  logic [NCELL-1:0]  w_cell_bit;
  logic [CARD_W-1:0] w_cell_card;
  logic [5:0]        w_next_x;
  logic [6:0]        w_down_end;

  assign w_active = (PLAYER == `P1 && cur_game_state == `GAME_P1_WAIT_IN) ||
                    (PLAYER == `P2 && cur_game_state == `GAME_P2_WAIT_IN);
  assign w_idx       = IDX_W'(mouse_block_y) * IDX_W'(COLS) + IDX_W'(mouse_block_x);
  assign w_cell_bit  = ONE_CELL << w_idx;
  assign w_cell_card = (int'(w_idx) < NCELL) ? map[w_idx*CARD_W +: CARD_W] : '0;
  // Six-bit successor so the last column cannot alias back to column 0.
  assign w_next_x    = {1'b0, r_end_x} + 6'd1;
  assign w_extend    = valid_card_take && (mouse_block_y == r_anchor_y) &&
                       ({1'b0, mouse_block_x} == w_next_x) && (r_len < MAX_LEN);
  assign w_on_anchor = (mouse_block_x == r_anchor_x) && (mouse_block_y == r_anchor_y);
  assign w_down_end  = {2'b00, mouse_block_x} + {4'b0000, r_len} - 7'd1;
  assign w_fits      = w_down_end < COLS_7;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;  r_anchor_x <= '0; r_anchor_y <= '0; r_end_x <= '0;
      r_len <= '0;        r_first_card <= '0; r_sel <= '0;    r_en <= 1'b0;
      r_done <= 1'b0;     r_bx <= '0;       r_by <= '0;       r_msg <= '0;
      r_card <= '0;       r_sel_len <= '0;
    end else if (interboard_rst) begin
      r_state <= S_IDLE;  r_anchor_x <= '0; r_anchor_y <= '0; r_end_x <= '0;
      r_len <= '0;        r_first_card <= '0; r_sel <= '0;    r_en <= 1'b0;
      r_done <= 1'b0;     r_bx <= '0;       r_by <= '0;       r_msg <= '0;
      r_card <= '0;       r_sel_len <= '0;
    end else begin
      r_en   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_active && l_click && valid_card_take) begin
          r_anchor_x   <= mouse_block_x;
          r_anchor_y   <= mouse_block_y;
          r_end_x      <= mouse_block_x;
          r_len        <= 3'd1;
          r_first_card <= w_cell_card;
          r_sel        <= w_cell_bit;
          r_state      <= S_SELECT;
        end
        S_SELECT: begin
          if (!w_active) begin
            r_sel   <= '0;
            r_len   <= '0;
            r_state <= S_IDLE;
          end else if (r_click) begin
            r_en      <= 1'b1;
            r_bx      <= r_anchor_x;
            r_by      <= r_anchor_y;
            r_sel_len <= r_len;
            r_card    <= r_first_card;
            r_msg     <= ({1'b0, r_anchor_y} < TROWS_4) ? `TABLE_TAKE : `HAND_TAKE;
            r_state   <= S_WAIT_SEND_TAKE;
          end else if (l_click) begin
            if (w_extend) begin
              r_len   <= r_len + 3'd1;
              r_end_x <= mouse_block_x;
              r_sel   <= r_sel | w_cell_bit;
            end else if (w_on_anchor && r_len == 3'd1) begin
              r_sel   <= '0;
              r_len   <= '0;
              r_state <= S_IDLE;
            end
          end
        end
        S_WAIT_SEND_TAKE: if (inter_ready) r_state <= S_WAIT_DOWN;
        S_WAIT_DOWN: if (w_active && l_click && valid_card_down && w_fits) begin
          r_en      <= 1'b1;
          r_bx      <= mouse_block_x;
          r_by      <= mouse_block_y;
          r_sel_len <= r_len;
          r_card    <= r_first_card;
          r_msg     <= ({1'b0, mouse_block_y} < TROWS_4) ? `TABLE_DOWN : `HAND_DOWN;
          r_state   <= S_WAIT_SEND_DOWN;
        end
        S_WAIT_SEND_DOWN: if (inter_ready) r_state <= S_FIN;
        S_FIN: begin
          r_done  <= 1'b1;
          r_sel   <= '0;
          r_len   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign move_done          = r_done;
  assign move_sel_card      = r_sel;
  assign move_ctrl_en       = r_en;
  assign move_ctrl_move_dir = 1'b0;
  assign move_ctrl_block_x  = r_bx;
  assign move_ctrl_block_y  = r_by;
  assign move_ctrl_msg_type = r_msg;
  assign move_ctrl_card     = r_card;
  assign move_ctrl_sel_len  = r_sel_len;
  assign dbg_state          = r_state;

endmodule

// File: tb/tb_handle_move_multi.sv
// Bench for handle_move_multi: directed scenarios plus randomized runs checked
// against a selection model built from a queue of selected columns.
`ifndef P1
`define P1 0
`endif
`ifndef P2
`define P2 1
`endif
`ifndef GAME_P1_WAIT_IN
`define GAME_P1_WAIT_IN 4'd2
`endif
`ifndef GAME_P2_WAIT_IN
`define GAME_P2_WAIT_IN 4'd6
`endif
`ifndef TABLE_TAKE
`define TABLE_TAKE 4'd1
`endif
`ifndef HAND_TAKE
`define HAND_TAKE 4'd2
`endif
`ifndef TABLE_DOWN
`define TABLE_DOWN 4'd3
`endif
`ifndef HAND_DOWN
`define HAND_DOWN 4'd4
`endif

module tb_handle_move_multi;
  localparam int COLS = 18, ROWS = 8, TABLE_ROWS = 6, CARD_W = 6, MAX_SEL = 5;
  localparam int NCELL = COLS * ROWS;

  logic clk = 1'b0, rst = 1'b1, interboard_rst = 1'b0;
  logic [3:0] cur_game_state = 4'd0;
  logic inter_ready = 1'b0, valid_card_take = 1'b0, valid_card_down = 1'b0;
  logic [NCELL*CARD_W-1:0] map = '0;
  logic l_click = 1'b0, r_click = 1'b0;
  logic [4:0] mouse_block_x = '0;
  logic [2:0] mouse_block_y = '0;
  logic move_done, move_ctrl_en, move_ctrl_move_dir;
  logic [NCELL-1:0] move_sel_card;
  logic [4:0] move_ctrl_block_x;
  logic [2:0] move_ctrl_block_y, move_ctrl_sel_len, dbg_state;
  logic [3:0] move_ctrl_msg_type;
  logic [CARD_W-1:0] move_ctrl_card;

  handle_move_multi #(.PLAYER(`P1), .COLS(COLS), .ROWS(ROWS), .TABLE_ROWS(TABLE_ROWS),
                      .CARD_W(CARD_W), .MAX_SEL(MAX_SEL)) dut (
    .clk(clk), .rst(rst), .interboard_rst(interboard_rst), .cur_game_state(cur_game_state),
    .inter_ready(inter_ready), .valid_card_take(valid_card_take),
    .valid_card_down(valid_card_down), .map(map), .l_click(l_click), .r_click(r_click),
    .mouse_block_x(mouse_block_x), .mouse_block_y(mouse_block_y), .move_done(move_done),
    .move_sel_card(move_sel_card), .move_ctrl_en(move_ctrl_en),
    .move_ctrl_move_dir(move_ctrl_move_dir), .move_ctrl_block_x(move_ctrl_block_x),
    .move_ctrl_block_y(move_ctrl_block_y), .move_ctrl_msg_type(move_ctrl_msg_type),
    .move_ctrl_card(move_ctrl_card), .move_ctrl_sel_len(move_ctrl_sel_len),
    .dbg_state(dbg_state));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  logic [CARD_W-1:0] cards [NCELL];
  // Reference selection: row of the run, its columns in click order, and the first card.
  int m_row;
  int m_cols[$];
  logic [CARD_W-1:0] m_first;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_map();
    for (int i = 0; i < NCELL; i++) begin
      cards[i] = CARD_W'($urandom);
      map[i*CARD_W +: CARD_W] = cards[i];
    end
  endtask

  function automatic logic [NCELL-1:0] model_mask();
    logic [NCELL-1:0] m = '0;
    foreach (m_cols[k]) m[m_row*COLS + m_cols[k]] = 1'b1;
    return m;
  endfunction

  task automatic lclick(input int x, input int y, input bit take, input bit down);
    mouse_block_x = 5'(x); mouse_block_y = 3'(y);
    valid_card_take = take; valid_card_down = down; l_click = 1'b1;
    tick();
    l_click = 1'b0; valid_card_take = 1'b0; valid_card_down = 1'b0;
  endtask

  task automatic ready_pulse();
    inter_ready = 1'b1; tick(); inter_ready = 1'b0;
  endtask

  task automatic sel_click(input int x, input int y, input bit take);
    if (m_cols.size() == 0) begin
      if (take) begin m_row = y; m_cols.push_back(x); m_first = cards[y*COLS + x]; end
    end else if (take && y == m_row && x == m_cols[$] + 1 && m_cols.size() < MAX_SEL)
      m_cols.push_back(x);
    else if (m_cols.size() == 1 && x == m_cols[0] && y == m_row)
      m_cols.delete();
    lclick(x, y, take, 1'b0);
    chk("sel_mask", move_sel_card, model_mask());
  endtask

  task automatic confirm();
    r_click = 1'b1; tick(); r_click = 1'b0;
    chk("take_en", move_ctrl_en, 1);
    chk("take_x", move_ctrl_block_x, m_cols[0]);
    chk("take_y", move_ctrl_block_y, m_row);
    chk("take_len", move_ctrl_sel_len, m_cols.size());
    chk("take_type", move_ctrl_msg_type, (m_row < TABLE_ROWS) ? `TABLE_TAKE : `HAND_TAKE);
    chk("take_card", move_ctrl_card, m_first);
    chk("move_dir", move_ctrl_move_dir, 0);
    tick();
    chk("take_en_pulse", move_ctrl_en, 0);
    repeat ($urandom_range(0, 3)) tick();
    chk("take_hold_x", move_ctrl_block_x, m_cols[0]);
    ready_pulse();
    chk("mask_kept", move_sel_card, model_mask());
  endtask

  task automatic down(input int x, input int y, output bit acc);
    acc = (cur_game_state == `GAME_P1_WAIT_IN) && (x + m_cols.size() - 1 < COLS);
    lclick(x, y, 1'b0, 1'b1);
    chk("down_en", move_ctrl_en, acc);
    if (acc) begin
      chk("down_x", move_ctrl_block_x, x);
      chk("down_y", move_ctrl_block_y, y);
      chk("down_type", move_ctrl_msg_type, (y < TABLE_ROWS) ? `TABLE_DOWN : `HAND_DOWN);
      chk("down_card", move_ctrl_card, m_first);
      chk("down_len", move_ctrl_sel_len, m_cols.size());
    end
  endtask

  task automatic finish_move();
    tick();
    chk("down_en_pulse", move_ctrl_en, 0);
    ready_pulse();
    chk("done_early", move_done, 0);
    tick();
    chk("done", move_done, 1);
    m_cols.delete();
    chk("mask_clear", move_sel_card, model_mask());
    tick();
    chk("done_pulse", move_done, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, move_ctrl_en, 0);
    chk({tag, "_done"}, move_done, 0);
    chk({tag, "_mask"}, move_sel_card, 0);
    chk({tag, "_x"}, move_ctrl_block_x, 0);
    chk({tag, "_y"}, move_ctrl_block_y, 0);
    chk({tag, "_type"}, move_ctrl_msg_type, 0);
    chk({tag, "_card"}, move_ctrl_card, 0);
    chk({tag, "_len"}, move_ctrl_sel_len, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    load_map();
    tick(); tick();
    chk_all_zero("reset");
    chk("reset_dir", move_ctrl_move_dir, 0);
    @(negedge clk); rst = 1'b0;
    cur_game_state = `GAME_P1_WAIT_IN;
    tick();

    // Single card from the table, dropped on another table row.
    sel_click(3, 2, 1'b1);
    chk("single_mask_bit39", move_sel_card[39], 1);
    confirm();
    down(7, 1, ok);
    chk("single_card39", move_ctrl_card, cards[39]);
    finish_move();

    // Run of three in the hand with two ignored clicks, then overflow check.
    sel_click(4, 6, 1'b1);
    sel_click(5, 6, 1'b1);
    sel_click(6, 6, 1'b1);
    sel_click(8, 6, 1'b1);
    sel_click(5, 5, 1'b1);
    chk("run3_mask", move_sel_card >> 112, 7);
    confirm();
    down(16, 0, ok);
    chk("overflow_ignored", ok, 0);
    down(15, 0, ok);
    finish_move();

    // Length capped at MAX_SEL.
    for (int k = 0; k < 6; k++) sel_click(10 + k, 1, 1'b1);
    chk("cap_len", m_cols.size(), 5);
    confirm();
    down(2, 7, ok);
    finish_move();

    // Cancel by re-clicking the anchor, and abort by losing the turn.
    sel_click(0, 0, 1'b1);
    sel_click(0, 0, 1'b1);
    chk("cancel_mask", move_sel_card, 0);
    sel_click(9, 3, 1'b1);
    cur_game_state = `GAME_P2_WAIT_IN;
    tick();
    m_cols.delete();
    chk("abort_mask", move_sel_card, 0);
    r_click = 1'b1; tick(); r_click = 1'b0;
    chk("abort_no_en", move_ctrl_en, 0);
    lclick(4, 4, 1'b1, 1'b0);
    chk("inactive_click", move_sel_card, 0);
    cur_game_state = `GAME_P1_WAIT_IN;
    tick();

    // Turn lost while waiting for the drop, and a stray ready there, both ignored.
    sel_click(1, 4, 1'b1);
    sel_click(2, 4, 1'b1);
    confirm();
    ready_pulse();
    cur_game_state = `GAME_P2_WAIT_IN;
    down(5, 1, ok);
    cur_game_state = `GAME_P1_WAIT_IN;
    down(5, 1, ok);
    chk("down_after_regain", ok, 1);
    finish_move();

    // Randomized selections and drops.
    for (int it = 0; it < 20; it++) begin
      int n;
      load_map();
      sel_click($urandom_range(0, COLS-1), $urandom_range(0, ROWS-1), 1'b1);
      n = $urandom_range(0, 6);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) != 0 && m_cols.size() > 0 && m_cols[$] + 1 < COLS)
          sel_click(m_cols[$] + 1, m_row, 1'b1);
        else
          sel_click($urandom_range(0, COLS-1), $urandom_range(0, ROWS-1),
                    1'($urandom_range(0, 1)));
      end
      if (m_cols.size() > 0) begin
        confirm();
        down($urandom_range(0, COLS-1), $urandom_range(0, ROWS-1), ok);
        if (!ok) down(0, $urandom_range(0, ROWS-1), ok);
        if (ok) finish_move();
      end
    end

    // Asynchronous reset while a drop is in flight.
    sel_click(6, 0, 1'b1);
    sel_click(7, 0, 1'b1);
    confirm();
    down(3, 5, ok);
    #3 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    m_cols.delete();
    @(negedge clk); rst = 1'b0;
    tick();

    // Synchronous interboard reset takes effect on the next edge.
    sel_click(12, 7, 1'b1);
    confirm();
    down(0, 2, ok);
    interboard_rst = 1'b1;
    chk("ibrst_before", move_sel_card, model_mask());
    tick();
    interboard_rst = 1'b0;
    m_cols.delete();
    chk_all_zero("ib_rst");
    tick();
    chk("ib_rst_idle_en", move_ctrl_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
